// File: rtl/fu_wb_arbiter_pkg.sv
// fu_wb_arbiter_pkg: shared functional-unit result type and writeback arbiter defaults.
package fu_wb_arbiter_pkg;
   localparam int unsigned WB_ARB_FUS = 3;
   typedef struct packed {
      logic       valid;
      logic [5:0] cause;
   } ex_t;
   typedef struct packed {
      logic [2:0]  index;
      logic [4:0]  rd;
      logic [31:0] result;
      ex_t         ex;
   } fu_result_t;
endpackage

// File: rtl/fu_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or after ptr_i.
module rr_arbiter #(
   parameter int unsigned NR_FU = 3,
   parameter int unsigned IDX_W = $clog2(NR_FU)
) (
   input  logic [NR_FU-1:0] req_i,
   input  logic [IDX_W-1:0] ptr_i,
   input  logic             en_i,
   output logic [NR_FU-1:0] gnt_o,
   output logic [IDX_W-1:0] idx_o
);
   logic [NR_FU-1:0] req_rot;
   logic [IDX_W-1:0] off;
   logic [IDX_W:0]   sum;
   logic             found;
   // Doubling the request vector turns the rotation into a plain shift.
   assign req_rot = NR_FU'({req_i, req_i} >> ptr_i);
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int k = NR_FU - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            found = 1'b1;
            off   = IDX_W'(k);
         end
      end
   end
   assign sum   = {1'b0, ptr_i} + {1'b0, off};
   assign idx_o = (sum >= (IDX_W+1)'(NR_FU)) ? IDX_W'(sum - (IDX_W+1)'(NR_FU)) : sum[IDX_W-1:0];
   assign gnt_o = (en_i && found) ? NR_FU'(1) << idx_o : '0;
endmodule

// File: rtl/fu_wb_arbiter.sv
// fu_wb_arbiter: round-robin writeback arbiter feeding a one-entry output stage.
module fu_wb_arbiter
   import fu_wb_arbiter_pkg::*;
#(
   parameter int unsigned NR_FU    = WB_ARB_FUS,
   parameter int unsigned FU_IDX_W = $clog2(NR_FU)
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      flush_i,
   input  logic [NR_FU-1:0]          fu_valid_i,
   input  fu_result_t [NR_FU-1:0]    fu_result_i,
   output logic [NR_FU-1:0]          fu_ready_o,
   output logic                      wb_valid_o,
   output fu_result_t                wb_result_o,
   output logic [FU_IDX_W-1:0]       wb_fu_o,
   input  logic                      wb_ready_i
);
   logic                wb_valid_q, wb_valid_d;
   fu_result_t          wb_result_q, wb_result_d;
   logic [FU_IDX_W-1:0] wb_fu_q, wb_fu_d, ptr_q, ptr_d, gnt_idx;
   logic                arb_en, grant;
   // Reset gates grants so no FU believes it transferred during the reset cycle.
   assign arb_en = rst_ni && !flush_i && (!wb_valid_q || wb_ready_i);
   rr_arbiter #(.NR_FU(NR_FU), .IDX_W(FU_IDX_W)) u_rr (
      .req_i (fu_valid_i),
      .ptr_i (ptr_q),
      .en_i  (arb_en),
      .gnt_o (fu_ready_o),
      .idx_o (gnt_idx)
   );
   assign grant = |fu_ready_o;
   always_comb begin
      wb_valid_d  = flush_i ? 1'b0 : grant ? 1'b1 : wb_ready_i ? 1'b0 : wb_valid_q;
      wb_result_d = grant ? fu_result_i[gnt_idx] : wb_result_q;
      wb_fu_d     = grant ? gnt_idx : wb_fu_q;
      ptr_d       = !grant ? ptr_q : (gnt_idx == FU_IDX_W'(NR_FU - 1)) ? '0 : gnt_idx + FU_IDX_W'(1);
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wb_valid_q  <= 1'b0;
         wb_result_q <= '0;
         wb_fu_q     <= '0;
         ptr_q       <= '0;
      end else begin
         wb_valid_q  <= wb_valid_d;
         wb_result_q <= wb_result_d;
         wb_fu_q     <= wb_fu_d;
         ptr_q       <= ptr_d;
      end
   end
   assign wb_valid_o  = wb_valid_q;
   assign wb_result_o = wb_result_q;
   assign wb_fu_o     = wb_fu_q;
endmodule

// File: tb/tb_fu_wb_arbiter.sv
// tb_fu_wb_arbiter: directed scoreboard bench for the writeback arbiter.
module tb_fu_wb_arbiter;
   import fu_wb_arbiter_pkg::*;
   typedef struct packed {
      fu_result_t r;
      logic [1:0] f;
   } exp_t;
   logic                clk = 1'b0;
   logic                rst_ni, flush_i, wb_ready_i, wb_valid_o;
   logic [2:0]          fu_valid_i, fu_ready_o;
   fu_result_t [2:0]    fu_result_i;
   fu_result_t          wb_result_o;
   logic [1:0]          wb_fu_o;
   exp_t                sb[$];
   exp_t                last;
   logic [2:0]          prev_xfer = '0;
   logic [2:0]          hold_q = '0;
   fu_result_t [2:0]    hold_res;
   int                  n_vec = 0;
   int                  n_err = 0;

   fu_wb_arbiter dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .flush_i     (flush_i),
      .fu_valid_i  (fu_valid_i),
      .fu_result_i (fu_result_i),
      .fu_ready_o  (fu_ready_o),
      .wb_valid_o  (wb_valid_o),
      .wb_result_o (wb_result_o),
      .wb_fu_o     (wb_fu_o),
      .wb_ready_i  (wb_ready_i)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic fu_result_t rnd_res();
      fu_result_t r;
      r.index    = 3'($urandom);
      r.rd       = 5'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      r.result   = $urandom;
      r.ex.valid = 1'($urandom);
      r.ex.cause = 6'($urandom);
      return r;
   endfunction

   function automatic logic [1:0] oh2idx(input logic [2:0] oh);
      return oh[0] ? 2'd0 : oh[1] ? 2'd1 : 2'd2;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // FU protocol: a stalled result must not change while still valid.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (hold_q[i] && fu_valid_i[i]) begin
            n_vec++;
            assert (fu_result_i[i] === hold_res[i]) else begin
               n_err++;
               $error("FAIL fu_stable[%0d]: observed %0h expected %0h", i, fu_result_i[i], hold_res[i]);
            end
         end
      end
      hold_q   <= fu_valid_i & ~fu_ready_o;
      hold_res <= fu_result_i;
   end

   task automatic step(input logic rst, input logic [2:0] v, input logic wr, input logic fl,
                       input logic [2:0] eg, input logic ev);
      @(negedge clk);
      rst_ni     = rst;
      fu_valid_i = v;
      wb_ready_i = wr;
      flush_i    = fl;
      for (int i = 0; i < 3; i++) if (prev_xfer[i]) fu_result_i[i] = rnd_res();
      #1;
      chk("fu_ready", 64'(fu_ready_o), 64'(eg));
      if (|eg) sb.push_back('{r: fu_result_i[oh2idx(eg)], f: oh2idx(eg)});
      @(posedge clk);
      #1;
      if (|eg && sb.size() > 0) last = sb.pop_front();
      chk("wb_valid", 64'(wb_valid_o), 64'(ev));
      if (ev) begin
         chk("wb_result", 64'(wb_result_o), 64'(last.r));
         chk("wb_fu", 64'(wb_fu_o), 64'(last.f));
      end
      if (!rst) begin
         chk("rst_result", 64'(wb_result_o), 64'd0);
         chk("rst_fu", 64'(wb_fu_o), 64'd0);
      end
      prev_xfer = v & eg;
   endtask

   initial begin
      rst_ni     = 1'b0;
      flush_i    = 1'b0;
      wb_ready_i = 1'b0;
      fu_valid_i = '0;
      for (int i = 0; i < 3; i++) fu_result_i[i] = rnd_res();
      // reset with everything requesting
      step(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0);
      step(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0);
      chk("rst_ptr", 64'(dut.ptr_q), 64'd0);
      // round-robin, one result per cycle
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b010, 1'b1);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b100, 1'b1);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b010, 1'b1);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b100, 1'b1);
      step(1'b1, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0);
      // single request from FU1
      fu_result_i[1] = '{index: 3'd5, rd: 5'd3, result: 32'hDEAD_BEEF, ex: '0};
      step(1'b1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b1);
      chk("single_index", 64'(wb_result_o.index), 64'd5);
      chk("single_rd", 64'(wb_result_o.rd), 64'd3);
      chk("single_data", 64'(wb_result_o.result), 64'hDEAD_BEEF);
      chk("single_fu", 64'(wb_fu_o), 64'd1);
      chk("single_ptr", 64'(dut.ptr_q), 64'd2);
      // back-pressure then release
      step(1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1);
      step(1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1);
      step(1'b1, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1);
      chk("bp_data", 64'(wb_result_o.result), 64'hDEAD_BEEF);
      step(1'b1, 3'b101, 1'b1, 1'b0, 3'b100, 1'b1);
      chk("bp_fu", 64'(wb_fu_o), 64'd2);
      // flush with the output full
      step(1'b1, 3'b001, 1'b0, 1'b1, 3'b000, 1'b0);
      chk("flush_ptr", 64'(dut.ptr_q), 64'd0);
      step(1'b1, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1);
      chk("post_flush_ptr", 64'(dut.ptr_q), 64'd1);
      // mid-operation reset
      step(1'b1, 3'b111, 1'b0, 1'b0, 3'b000, 1'b1);
      step(1'b0, 3'b111, 1'b1, 1'b0, 3'b000, 1'b0);
      chk("mid_rst_ptr", 64'(dut.ptr_q), 64'd0);
      step(1'b1, 3'b111, 1'b1, 1'b0, 3'b001, 1'b1);
      chk("mid_rst_fu", 64'(wb_fu_o), 64'd0);
      chk("sb_empty", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Writeback arbiter between the functional units (ALU, CSR, LSU load path) and the scoreboard's single result-writeback port. Each FU presents a `fu_result_t` under a valid/ready handshake. The arbiter picks one per cycle using rotating round-robin priority and registers it into a one-entry output stage. The output stage holds the result until the scoreboard accepts it, and `flush_i` discards all in-flight writeback on mispredict or exception.

## Interface
Parameters:
- `NR_FU`, default 3: number of requesting functional units; must be ≥ 2 (not required to be a power of two).
- `FU_IDX_W`, default `$clog2(NR_FU)`: width of the round-robin pointer.

Ports:
- `clk_i`, input, 1: clock. One clock only; everything updates on its rising edge.
- `rst_ni`, input, 1: reset, synchronous and active-low.
- `flush_i`, input, 1: discard the held result and block grants this cycle.
- `fu_valid_i`, input, `NR_FU`: FU *i* has a result.
- `fu_result_i`, input, `NR_FU` x `fu_result_t`: per-FU result (index, rd, result, ex).
- `fu_ready_o`, output, `NR_FU`: grant to FU *i*; transfer occurs when valid and ready are both high.
- `wb_valid_o`, output, 1: output stage holds a result.
- `wb_result_o`, output, `fu_result_t`: registered winning result.
- `wb_fu_o`, output, `FU_IDX_W`: which FU produced `wb_result_o`.
- `wb_ready_i`, input, 1: scoreboard accepts `wb_result_o` this cycle.

## Operation
- State: output register (`wb_valid_q`, `wb_result_q`, `wb_fu_q`) and round-robin pointer `ptr_q`.
- Slot free: `slot_free = !wb_valid_q || wb_ready_i`.
- Grant search:
  - Find the first *i* with `fu_valid_i[i]`, scanning `ptr_q, ptr_q+1, …` modulo `NR_FU` with explicit wrap.
  - At most one `fu_ready_o` bit is high.
  - That bit is high only if `slot_free && !flush_i` and a request exists.
  - Ready is combinational from valid, so FUs must not make valid depend on ready.
- On a grant to *i*:
  - The output register loads `fu_result_i[i]`, with `wb_fu_q = i`.
  - `ptr_q` becomes *i*+1, wrapping from `NR_FU`-1 to 0.
- No grant with `wb_ready_i` high: `wb_valid_q` is cleared.
- No grant with `wb_ready_i` low: the output register holds.
- `ptr_q` changes only on a grant.
- `flush_i` is high:
  - All `fu_ready_o` are 0.
  - `wb_valid_q` is 0 next cycle, regardless of `wb_ready_i`.
  - `ptr_q` is unchanged.
  - FUs are flushed separately and must drop their own valid.
- Results are passed unmodified, including `ex.valid` and `rd == 0`. The arbiter does not filter them.
- Fairness: a continuously valid FU is granted within `NR_FU` grants.
- FU protocol rule: `fu_result_i[i]` must stay stable while valid is high and ready is low. The bench asserts this.

## Timing
- Reset values:
  - `wb_valid_o` = 0.
  - `wb_result_o` = all zero.
  - `wb_fu_o` = 0.
  - `ptr_q` = 0.
  - `fu_ready_o` = 0 during the reset cycle.
- Latency: a handshake in cycle *t* puts the result on `wb_valid_o`/`wb_result_o` in *t*+1.
- Throughput: one result per cycle while `wb_ready_i` stays high.
- Accept and refill in the same cycle: when `wb_ready_i` is high with the output full, a new grant in that cycle replaces the result with no bubble.
- Back-pressure: when the output is full and `wb_ready_i` is low, all `fu_ready_o` are 0 and the output is held bit-stable.
- Flush and `wb_ready_i` in the same cycle: flush wins. The held result counts as accepted-or-dropped; the scoreboard ignores it under flush.
- Reset mid-operation overrides flush and grants. The held result is lost.

## Structure
- `fu_result_t` is already shared; no new typedef is needed.
- Add `WB_ARB_FUS` (= 3) to the shared package as the default for `NR_FU`.
- One sub-module: `rr_arbiter`.
  - Purely combinational.
  - Inputs: `req[NR_FU]`, `ptr`, `en`.
  - Outputs: one-hot `gnt` and the binary `idx`.
  - Implemented by a double-width request vector rotated by `ptr`, then a priority encoder.
- `fu_wb_arbiter` holds the output register, the pointer register and the flush logic.

## Test plan
- Reset: hold `rst_ni` low for 2 cycles with all FUs valid → `fu_ready_o` = 0, `wb_valid_o` = 0 and `wb_result_o` = 0 throughout; the first grant after release goes to FU0.
- Single request: FU1 valid with index 5, rd 3, result 0xDEAD_BEEF → `fu_ready_o` = 3'b010 in that cycle; next cycle `wb_valid_o` = 1 with index 5, rd 3, 0xDEAD_BEEF and `wb_fu_o` = 1; then `ptr_q` = 2.
- Round-robin: all 3 FUs continuously valid and `wb_ready_i` = 1 → grant order 0,1,2,0,1,2; one `wb_valid_o` per cycle with no bubbles.
- Back-pressure:
  - Output full and `wb_ready_i` = 0 for 3 cycles with FU0 and FU2 valid → no grants and a stable `wb_result_o`.
  - When `wb_ready_i` rises, the next-priority FU is granted in that same cycle and appears the following cycle.
- Flush: output full and FU0 valid, assert `flush_i` for 1 cycle → `fu_ready_o` = 0 that cycle; next cycle `wb_valid_o` = 0 and `ptr_q` is unchanged.
- Mid-operation reset: pulse `rst_ni` low while the output is full and requests are pending → the next cycle matches the reset values and the pointer restarts at FU0.
